// File: rtl/bs_pkg.sv
// ---------------------------------------------------------------------------
// bs_pkg
//   Shared definitions for the pipelined barrel shifter.
//
//   Contents:
//     bs_op_t           2-bit shift/rotate mode
//       BS_SLL  2'b00   logical shift left, zero fill
//       BS_SRL  2'b01   logical shift right, zero fill
//       BS_SRA  2'b10   arithmetic shift right, MSB fill
//       BS_ROR  2'b11   rotate right
//     BS_DEFAULT_WIDTH  default datapath width
//     bs_is_right()     true for the modes that move bits toward bit 0
// ---------------------------------------------------------------------------
package bs_pkg;

    typedef enum logic [1:0] {
        BS_SLL = 2'b00,
        BS_SRL = 2'b01,
        BS_SRA = 2'b10,
        BS_ROR = 2'b11
    } bs_op_t;

    localparam int BS_DEFAULT_WIDTH = 8;

    // Every mode except SLL moves data toward the LSB.
    function automatic logic bs_is_right(input bs_op_t op);
        return (op != BS_SLL);
    endfunction

endpackage : bs_pkg

// File: rtl/bs_stage.sv
// ---------------------------------------------------------------------------
// bs_stage
//   One stage of the pipelined barrel shifter. Applies a fixed shift/rotate
//   of 2**K positions when amount bit K is set, then registers the result
//   together with the amount, the op and a valid flag.
//
//   Parameters:
//     WIDTH  datapath width (power of two, >= 2)
//     SHW    shift-amount width, $clog2(WIDTH)
//     K      stage index; this stage resolves amount bit K
//
//   Ports:
//     clk      in   clock, rising edge
//     rst_n    in   asynchronous active-low reset
//     i_valid  in   upstream word present
//     i_data   in   upstream data
//     i_amt    in   upstream shift amount (full width, bit K used here)
//     i_op     in   upstream mode
//     i_ready  in   the next stage (or the consumer) loads this cycle
//     o_load   out  this stage loads this cycle (its upstream ready)
//     o_valid  out  registered valid
//     o_data   out  registered data
//     o_amt    out  registered shift amount
//     o_op     out  registered mode
// ---------------------------------------------------------------------------
module bs_stage
    import bs_pkg::*;
#(
    parameter int WIDTH = BS_DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH),
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    input  bs_op_t           i_op,
    input  logic             i_ready,
    output logic             o_load,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [SHW-1:0]   o_amt,
    output bs_op_t           o_op
);

    localparam int SH = 1 << K;

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amt;
    bs_op_t           r_op;

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;
    logic             w_load;

    // Fixed-distance shift/rotate. SRA replicates the MSB of the word as it
    // arrives at this stage; earlier SRA stages already filled with the
    // original sign, so the current MSB always equals it.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_shifted = i_data;
        case (i_op)
            BS_SLL:  w_shifted = {i_data[WIDTH-SH-1:0], {SH{1'b0}}};
            BS_SRL:  w_shifted = {{SH{1'b0}}, i_data[WIDTH-1:SH]};
            BS_SRA:  w_shifted = {{SH{i_data[WIDTH-1]}}, i_data[WIDTH-1:SH]};
            BS_ROR:  w_shifted = {i_data[SH-1:0], i_data[WIDTH-1:SH]};
            default: w_shifted = i_data;
        endcase
    end

    assign w_next = i_amt[K] ? w_shifted : i_data;

    // Load when empty or when the content is taken downstream this cycle;
    // this lets a bubble be squeezed out while the output is stalled.
    assign w_load = !r_valid || i_ready;
    assign o_load = w_load;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the pipe shifts as one.
    // NOTE: data/amt/op registers are reset too, so out_data reads 0 during
    // and after reset rather than leftover contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_op    <= BS_SLL;
        end else if (w_load) begin
            r_valid <= i_valid;
            // Payload only moves with a real word; an empty slot keeps its
            // old (don't-care) payload.
            if (i_valid) begin
                r_data <= w_next;
                r_amt  <= i_amt;
                r_op   <= i_op;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_op    = r_op;

endmodule : bs_stage

// File: rtl/barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// barrel_shifter_pipe
//   Pipelined barrel shifter with valid/ready on both sides. Stage k resolves
//   shift-amount bit k, giving SHW register stages, one word per clock and
//   full backpressure with bubble collapsing.
//
//   Parameters:
//     WIDTH  data width, power of two, >= 2
//     SHW    derived, $clog2(WIDTH): amount width and pipeline depth
//
//   Ports:
//     clk        in   clock, rising edge
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   input word present
//     in_ready   out  input word accepted this cycle if in_valid
//     in_data    in   operand
//     in_amt     in   shift amount, 0..WIDTH-1
//     in_op      in   mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR
//     out_valid  out  result present
//     out_ready  in   consumer takes the result this cycle
//     out_data   out  shifted/rotated result
// ---------------------------------------------------------------------------
module barrel_shifter_pipe
    import bs_pkg::*;
#(
    parameter  int WIDTH = BS_DEFAULT_WIDTH,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
        $error("barrel_shifter_pipe: WIDTH must be a power of two >= 2");
    end

    // Index 0 is the pipe input, index k+1 is the register of stage k.
    logic [SHW:0]            w_valid;
    logic [SHW:0][WIDTH-1:0] w_data;
    logic [SHW:0][SHW-1:0]   w_amt;
    bs_op_t                  w_op [SHW+1];

    // w_take[k]: whatever sits downstream of stage k loads this cycle.
    logic [SHW-1:0]          w_take;
    logic [SHW-1:0]          w_load;
    logic                    w_unused;

    assign w_valid[0] = in_valid;
    assign w_data[0]  = in_data;
    assign w_amt[0]   = in_amt;
    assign w_op[0]    = bs_op_t'(in_op);

    // The ready chain is built here from the registered valid bits, walking
    // back from the consumer, so it depends only on out_ready and state and
    // never on in_valid.
    always_comb begin
        w_take = '0;
        w_take[SHW-1] = out_ready;
        for (int k = SHW - 2; k >= 0; k--) begin
            w_take[k] = !w_valid[k+2] || w_take[k+1];
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        bs_stage #(
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .K     (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_amt   (w_amt[k]),
            .i_op    (w_op[k]),
            .i_ready (w_take[k]),
            .o_load  (w_load[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_amt   (w_amt[k+1]),
            .o_op    (w_op[k+1])
        );
    end

    assign in_ready  = w_load[0];
    assign out_valid = w_valid[SHW];
    assign out_data  = w_data[SHW];

    // Amount and op are fully consumed by the last stage; their registered
    // copies at the pipe tail (and the inner load flags) have no reader.
    assign w_unused = ^{w_amt[SHW], w_op[SHW], w_load};

endmodule : barrel_shifter_pipe

// File: tb/tb_barrel_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_barrel_shifter_pipe
//   Self-checking bench for barrel_shifter_pipe at WIDTH = 8.
// ---------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

    localparam int WIDTH = 8;
    localparam int NV    = 13;
    localparam int NRAND = 10000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [2:0]       in_amt = '0;
    logic [1:0]       in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb_q [$];

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [2:0] amt;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [NV];

    bit did_push, did_pop;
    int idx, pushed_n, cyc;

    barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference result computed directly from the whole shift amount.
    function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] d,
                                         input logic [2:0] a);
        logic [15:0] t;
        case (op)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return 8'($signed(d) >>> a);
            default: begin
                t = {d, d} >> a;
                return t[7:0];
            end
        endcase
    endfunction

    // Called just after a falling edge with inputs already driven. Decides
    // the transfers of the coming rising edge, scores a pop, queues a push.
    task automatic cycle(output bit pushed, output bit popped);
        #1;
        pushed = in_valid && in_ready;
        popped = out_valid && out_ready;
        if (popped) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected no output", out_data);
            end else begin
                check("sb_data", out_data, sb_q.pop_front());
            end
        end
        if (pushed) sb_q.push_back(model(in_op, in_data, in_amt));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 8'hB5, 3'd3, 8'hA8};
        vecs[1]  = '{2'b01, 8'hB5, 3'd3, 8'h16};
        vecs[2]  = '{2'b10, 8'hB5, 3'd3, 8'hF6};
        vecs[3]  = '{2'b10, 8'h35, 3'd7, 8'h00};
        vecs[4]  = '{2'b11, 8'hB5, 3'd3, 8'hB6};
        vecs[5]  = '{2'b00, 8'h5A, 3'd0, 8'h5A};
        vecs[6]  = '{2'b01, 8'h5A, 3'd0, 8'h5A};
        vecs[7]  = '{2'b10, 8'h5A, 3'd0, 8'h5A};
        vecs[8]  = '{2'b11, 8'h5A, 3'd0, 8'h5A};
        vecs[9]  = '{2'b00, 8'h01, 3'd7, 8'h80};
        vecs[10] = '{2'b10, 8'h80, 3'd7, 8'hFF};
        vecs[11] = '{2'b11, 8'h81, 3'd4, 8'h18};
        vecs[12] = '{2'b01, 8'h80, 3'd7, 8'h01};

        // Reset state.
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Single words: exact latency and result.
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_op    = vecs[i].op;
            in_data  = vecs[i].data;
            in_amt   = vecs[i].amt;
            #1;
            check($sformatf("tbl_in_ready[%0d]", i), in_ready, 1);
            @(posedge clk);                 // acceptance edge N
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);                 // N+1
            @(negedge clk);
            check($sformatf("tbl_early[%0d]", i), out_valid, 0);
            @(posedge clk);                 // N+2
            @(negedge clk);
            check($sformatf("tbl_valid[%0d]", i), out_valid, 1);
            check($sformatf("tbl_data[%0d]", i), out_data, vecs[i].exp);
            @(posedge clk);                 // consumed
            @(negedge clk);
            check($sformatf("tbl_gone[%0d]", i), out_valid, 0);
        end

        // amt = 0 on every op back-to-back, checked in order by the scoreboard.
        for (int i = 5; i <= 8; i++) begin
            in_valid = 1'b1;
            in_op    = vecs[i].op;
            in_data  = vecs[i].data;
            in_amt   = vecs[i].amt;
            cycle(did_push, did_pop);
            check("amt0_accept", did_push, 1);
        end
        in_valid = 1'b0;
        repeat (4) cycle(did_push, did_pop);
        check("amt0_drained", sb_q.size(), 0);

        // Backpressure: 8 words offered with the consumer stalled.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_op    = 2'(idx);
            in_data  = 8'hC3 ^ 8'(idx * 17);
            in_amt   = 3'(idx + 1);
            cycle(did_push, did_pop);
            if (did_push) idx++;
        end
        check("stall_accepts", idx, 3);
        #1;
        check("stall_in_ready", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            check("stall_valid", out_valid, 1);
            check("stall_hold", out_data, (sb_q.size() != 0) ? sb_q[0] : 8'hxx);
            cycle(did_push, did_pop);
        end
        out_ready = 1'b1;
        #1;
        check("ready_reassert", in_ready, 1);
        for (int c = 0; c < 8; c++) begin
            check("drain_cont", out_valid, 1);
            in_valid = (idx < 8);
            in_op    = 2'(idx);
            in_data  = 8'hC3 ^ 8'(idx * 17);
            in_amt   = 3'(idx + 1);
            cycle(did_push, did_pop);
            if (did_push) idx++;
        end
        check("stream_all_accepted", idx, 8);
        check("stream_drained", sb_q.size(), 0);
        in_valid = 1'b0;

        // Random traffic against the reference model.
        pushed_n = 0;
        cyc = 0;
        while ((pushed_n < NRAND || sb_q.size() != 0) && cyc < 60000) begin
            in_valid  = (pushed_n < NRAND) && ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_amt    = 3'($urandom);
            in_op     = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle(did_push, did_pop);
            if (did_push) pushed_n++;
            cyc++;
        end
        check("rand_pushed", pushed_n, NRAND);
        check("rand_drained", sb_q.size(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle(did_push, did_pop);

        // Reset with a full pipe.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_op    = 2'(c);
            in_data  = 8'h9F + 8'(c);
            in_amt   = 3'(c);
            cycle(did_push, did_pop);
        end
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        sb_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("no_stale", out_valid, 0);
            cycle(did_push, did_pop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_barrel_shifter_pipe

// File: doc/barrel_shifter_pipe.md
# barrel_shifter_pipe

Parametrised, pipelined barrel shifter that generalises the team's fixed 4-bit 2:1-mux shifter datapath to any power-of-two width. It supports four shift/rotate modes and has a valid/ready stream interface on both sides. Each bit of the shift amount is resolved in its own registered mux stage, giving a throughput of one word per clock with full backpressure. It sits between the operand-fetch stream and the ALU result stream.

## Interface
Parameters:
- WIDTH, 8, data width in bits; power of two, at least 2.
- SHW, $clog2(WIDTH), derived localparam, not overridable; shift-amount width and pipeline depth.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept an input word this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift amount, 0 to WIDTH-1.
- in_op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  shifted or rotated result.

## Operation
- A transfer occurs on an edge where valid and ready are both high, on either side.
- Stage k (k = 0..SHW-1) applies a shift of 2^k when amt[k] = 1, and passes data through unchanged otherwise.
- Each stage registers data, the remaining amt bits, op, and a valid bit.
- Mode behaviour at each stage:
  - SLL: zero-fill the low bits.
  - SRL: zero-fill the high bits.
  - SRA: fill with the operand's bit WIDTH-1. Each stage re-reads the current MSB, which gives the same result as the original sign.
  - ROR: bits leaving the low end enter the high end.
- Stage advance rule: stage k loads when its register is empty or stage k+1 (or the consumer, for the last stage) takes its content in the same cycle. This collapses bubbles.
- in_ready = !valid[0] || advance[0]. in_ready is combinational from out_ready through the ready chain, with no combinational path from in_valid.
- When in_valid = 0, stage 0 becomes empty on advance. Data registers need not be cleared.
- Words leave in strict acceptance order. No word is dropped or duplicated.
- in_amt = 0 passes in_data unchanged for every op.

## Timing
- Reset (asynchronous, while rst_n = 0):
  - all stage valid bits = 0, so out_valid = 0;
  - all data registers = 0, so out_data = 0;
  - in_ready = 1 once reset is released (an empty pipe is always ready).
- Latency: a word accepted on edge N appears on out_data with out_valid = 1 right after edge N+SHW-1. This is SHW register stages, with stage 0 capturing on the acceptance edge.
- Throughput: one word per cycle while out_ready stays high.
- Capacity: SHW words in flight. With out_ready held low, in_ready drops after SHW accepted words. It re-asserts in the same cycle that out_ready rises.
- Simultaneous output pop and input push with the pipe full: both complete on the same edge.
- out_valid and out_data must remain stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-stream: all in-flight words are discarded immediately, and outputs take their reset values asynchronously.

## Structure
- Shared package bs_pkg holds:
  - the op encoding constants BS_SLL, BS_SRL, BS_SRA, BS_ROR;
  - the 2-bit op typedef bs_op_t.
- One sub-module, bs_stage, parametrised by WIDTH and its stage index k:
  - a combinational 2^k shift/rotate mux followed by the stage register, with valid/ready handling;
  - barrel_shifter_pipe instantiates SHW copies of it in a generate loop.

## Test plan
All scenarios use WIDTH = 8 (SHW = 3).
- SLL, data 8'hB5, amt 3 -> 8'hA8. SRL, same data and amt -> 8'h16. Each result appears right after edge N+2 of its acceptance edge N.
- SRA, data 8'hB5, amt 3 -> 8'hF6. SRA, data 8'h35, amt 7 -> 8'h00. ROR, data 8'hB5, amt 3 -> 8'hB6.
- All four ops with amt 0 on data 8'h5A -> 8'h5A each, in input order.
- Stream 8 words with out_ready = 0 from the start:
  - in_ready falls after exactly 3 accepts;
  - raising out_ready drains them in order, with out_data held stable while stalled;
  - the remaining words follow at one per cycle.
- Random out_ready and in_valid over 10k words with all ops and amounts, checked against a reference model -> zero mismatches, order preserved.
- Assert rst_n with 3 words in flight -> out_valid = 0 and out_data = 0 immediately. After release, in_ready = 1 and no stale word is emitted.
